io_supply_seq: RTL

IO_SUPPLY_SEQ -- requirements
Module: io_supply_seq

---
 rtl/io_supply_seq_if.sv | 34 +++
 rtl/io_supply_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/io_supply_seq_if.sv
// Handshake and pad-ring signals of the IO supply sequencer.
// The slave modport is the sequencer's view; the master modport is the core/pad-ring side.
interface io_supply_seq_if;
  logic pwr_req;
  logic pwr_ack;
  logic vsup_en;
  logic pg_in;
  logic iso_n;
  logic busy;
  logic fault;
  logic fault_clr;

  modport slave (
    input  pwr_req,
    input  pg_in,
    input  fault_clr,
    output pwr_ack,
    output vsup_en,
    output iso_n,
    output busy,
    output fault
  );

  modport master (
    output pwr_req,
    output pg_in,
    output fault_clr,
    input  pwr_ack,
    input  vsup_en,
    input  iso_n,
    input  busy,
    input  fault
  );
endinterface

// File: rtl/io_supply_seq.sv
// IO supply power-up/power-down sequencer with pad isolation control and sticky fault.
// Optional power-good timeout in WAIT_PG is enabled by defining IO_SUPPLY_SEQ_TIMEOUT_EN.
module io_supply_seq #(
  parameter int RAMP_CYCLES    = 100,
  parameter int ISO_DLY        = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  io_supply_seq_if.slave bus
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_RAMP    = 3'd1;
  localparam logic [2:0] ST_WAIT_PG = 3'd2;
  localparam logic [2:0] ST_ISO_REL = 3'd3;
  localparam logic [2:0] ST_ON      = 3'd4;
  localparam logic [2:0] ST_ISO_SET = 3'd5;
  localparam logic [2:0] ST_DOWN    = 3'd6;
  localparam logic [2:0] ST_FAULT   = 3'd7;

  localparam logic [15:0] RAMP_LOAD    = 16'(RAMP_CYCLES - 1);
  localparam logic [15:0] ISO_LOAD     = 16'(ISO_DLY - 1);
  localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic        pg_meta_r, pg_s;
  logic        ack_r, vsup_r, iso_r, busy_r, fault_r;
  logic        ack_s, vsup_s, iso_s, busy_s, fault_s;

  // Two-flop synchroniser for the asynchronous power-good input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_meta_r <= 1'b0;
      pg_s      <= 1'b0;
    end else begin
      pg_meta_r <= bus.pg_in;
      pg_s      <= pg_meta_r;
    end
  end

  // Next-state and shared wait-counter logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_OFF: begin
        if (bus.pwr_req) begin
          state_s = ST_RAMP;
          cnt_s   = RAMP_LOAD;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_RAMP: begin
        if (!bus.pwr_req) begin
          state_s = ST_DOWN;
          cnt_s   = RAMP_LOAD;
        end else if (cnt_r == 16'd0) begin
          state_s = ST_WAIT_PG;
          cnt_s   = TIMEOUT_LOAD;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_WAIT_PG: begin
        if (!bus.pwr_req) begin
          state_s = ST_DOWN;
          cnt_s   = RAMP_LOAD;
        end else if (pg_s) begin
          state_s = ST_ISO_REL;
          cnt_s   = ISO_LOAD;
`ifdef IO_SUPPLY_SEQ_TIMEOUT_EN
        end else if (cnt_r == 16'd0) begin
          state_s = ST_FAULT;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
`else
        end else begin
          cnt_s = cnt_r;
        end
`endif
      end
      ST_ISO_REL: begin
        if (!pg_s) begin
          state_s = ST_FAULT;
        end else if (cnt_r == 16'd0) begin
          state_s = ST_ON;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_ON: begin
        // Loss of power-good wins over a simultaneous power-down request
        if (!pg_s) begin
          state_s = ST_FAULT;
        end else if (!bus.pwr_req) begin
          state_s = ST_ISO_SET;
          cnt_s   = ISO_LOAD;
        end else begin
          state_s = ST_ON;
        end
      end
      ST_ISO_SET: begin
        if (cnt_r == 16'd0) begin
          state_s = ST_DOWN;
          cnt_s   = RAMP_LOAD;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_DOWN: begin
        if (cnt_r == 16'd0) begin
          state_s = ST_OFF;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr && !bus.pwr_req) begin
          state_s = ST_OFF;
          cnt_s   = 16'd0;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_OFF;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    vsup_s  = 1'b0;
    iso_s   = 1'b0;
    ack_s   = 1'b0;
    busy_s  = 1'b0;
    fault_s = 1'b0;
    case (state_s)
      ST_OFF: begin
        busy_s = 1'b0;
      end
      ST_RAMP, ST_WAIT_PG: begin
        vsup_s = 1'b1;
        busy_s = 1'b1;
      end
      ST_ISO_REL: begin
        vsup_s = 1'b1;
        iso_s  = 1'b1;
        busy_s = 1'b1;
      end
      ST_ON: begin
        vsup_s = 1'b1;
        iso_s  = 1'b1;
        ack_s  = 1'b1;
      end
      ST_ISO_SET: begin
        vsup_s = 1'b1;
        ack_s  = 1'b1;
        busy_s = 1'b1;
      end
      ST_DOWN: begin
        // Ack is held only through a DOWN that follows an acknowledged ON
        ack_s  = ack_r;
        busy_s = 1'b1;
      end
      ST_FAULT: begin
        fault_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_OFF;
      cnt_r   <= 16'd0;
      ack_r   <= 1'b0;
      vsup_r  <= 1'b0;
      iso_r   <= 1'b0;
      busy_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= ack_s;
      vsup_r  <= vsup_s;
      iso_r   <= iso_s;
      busy_r  <= busy_s;
      fault_r <= fault_s;
    end
  end

  assign bus.pwr_ack = ack_r;
  assign bus.vsup_en = vsup_r;
  assign bus.iso_n   = iso_r;
  assign bus.busy    = busy_r;
  assign bus.fault   = fault_r;

endmodule
